keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver on the Elbert V2 board tests.
- The display driver strobes digit enables and writes segments. This block strobes the columns of a 4x4 matrix keypad and reads back its rows.
- It debounces the result and delivers a 4-bit hex key code with a one-cycle press strobe.
- Its output feeds the same hex-digit datapath (e.g. as a digit source for the display mux or as a counter command input).

Parameters:
- SCAN_DIV, 6000: clk cycles per column step. 12 MHz / 6000 = 2 kHz column rate, 500 Hz full-frame rate. Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical frames needed to accept a press or a release. Range 1..15.
- REPEAT_DELAY, 250: frames held before the first auto-repeat. Used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE, 50: frames between later auto-repeats. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous
- col_n  output  4  keypad column strobes, active-low, exactly one low at a time
- key_code  output  4  code of the last accepted key = row_index*4 + col_index
- key_valid  output  1  one-cycle pulse per accepted press (and per repeat, if enabled)
- key_held  output  1  high while a debounced key is held

Behaviour:
- Reset values:
  - col_n = 4'b1110 (column 0 driven)
  - key_code = 0, key_valid = 0, key_held = 0
  - prescaler, column index, debounce counter, candidate = 0
  - state = IDLE
- Synchronizer: row_n passes through a 2-flop synchronizer before any use.
- Prescaler: counts 0..SCAN_DIV-1 and produces a tick on the terminal count.
- On each tick:
  - Sample the synchronized rows for the currently driven column.
  - Advance the column index (3 wraps to 0) and drive the next col_n on the following cycle.
  - Each column is therefore driven for exactly SCAN_DIV cycles, so rows have settled before sampling.
- Frame result: evaluated on the tick that samples column 3.
  - NONE: no row low in any column.
  - SINGLE(k): exactly one row/column intersection low.
  - MULTI: two or more intersections low. MULTI is treated as NONE for debounce (no ghost/rollover keys).
- State machine: transitions occur only on the frame-completing tick.
  - IDLE:
    - SINGLE(k): candidate = k, cnt = 1, go to DEBOUNCE.
    - If DEBOUNCE_SCANS == 1, go directly to PRESSED instead.
  - DEBOUNCE:
    - SINGLE(candidate): cnt++. When cnt == DEBOUNCE_SCANS: go to PRESSED, key_code = candidate, key_held = 1, key_valid pulses.
    - SINGLE(j != candidate): candidate = j, cnt = 1, stay.
    - NONE/MULTI: go to IDLE.
  - PRESSED:
    - SINGLE(candidate): stay.
    - Anything else: cnt = 1, go to RELEASE.
  - RELEASE:
    - SINGLE(candidate): return to PRESSED; no new key_valid.
    - Anything else: cnt++. When cnt == DEBOUNCE_SCANS: key_held = 0, go to IDLE.
- Output timing:
  - key_valid is high for exactly the one clk cycle after the frame-completing tick.
  - key_code and key_held update on that same cycle.
  - key_code holds its value after release until the next accepted press.
- Bounce mid-debounce restarts the count. A different key pressed while one is held produces no key_valid until the held key has been released and debounced.
- Reset asserted mid-scan or mid-debounce returns all state and outputs to their reset values on the next clock edge. No key_valid is produced for a frame interrupted by reset.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a frame counter counts consecutive held frames.
  - key_valid re-pulses, with unchanged key_code, after REPEAT_DELAY frames, then every REPEAT_RATE frames.
  - The counter clears on leaving PRESSED. A RELEASE→PRESSED bounce does not restart the repeat delay.
- Undefined: exactly one key_valid per debounced press, and no repeat logic or parameters are synthesized.

Test Plan:
(Simulation parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3, so one frame = 16 clk cycles.)
- Reset, no key: col_n cycles 1110→1101→1011→0111, each held 4 cycles. key_valid never asserts; key_held = 0.
- Key 6 (row 1, column 2) held clean: key_valid single pulse at the end of the 3rd full frame; key_code = 4'h6; key_held = 1. On release, key_held falls 3 frames later.
- Key 6 pressed with bounce (1 frame present, 1 absent, then steady): no pulse until 3 consecutive SINGLE(6) frames, then exactly one pulse.
- Keys 0 and 5 held together: MULTI throughout, no key_valid, key_held = 0. Release key 5: key 0 accepted after 3 frames, key_code = 4'h0.
- Reset asserted while in DEBOUNCE with cnt = 2: next cycle col_n = 1110 and all outputs 0. A held key needs 3 full new frames before key_valid.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, key F held 12 frames after acceptance: key_valid pulses at acceptance, then at +5, +7, +9 and +11 frames; key_code = 4'hF throughout.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row sampling, frame debounce, hex key code + press strobe.
// Optional auto-repeat of a held key is built only when KEYPAD_REPEAT_EN is defined.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_DIV       = 6000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 250,
  parameter int REPEAT_RATE    = 50
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  logic [PW-1:0] presc_q;
  logic [1:0]    col_idx_q;
  logic [3:0]    col_n_q;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [1:0]    frame_cnt_q, frame_cnt_d;
  logic [3:0]    frame_code_q, code_d;
  logic [2:0]    hits;
  logic [2:0]    sum;
  logic [1:0]    col_row;
  logic [1:0]    col_nx;
  logic          tick, frame_done, single;

  state_t        state_q;
  logic [3:0]    cand_q;
  logic [3:0]    cnt_q, cnt_nx;
  logic [3:0]    key_code_q;
  logic          key_valid_q, key_held_q;
`ifdef KEYPAD_REPEAT_EN
  logic [15:0]   rpt_q;
`endif

  assign tick       = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_done = tick && (col_idx_q == 2'd3);
  assign col_nx     = col_idx_q + 2'd1;
  assign cnt_nx     = cnt_q + 4'd1;

  // Intersections seen so far this frame saturate at 2: anything above one is MULTI.
  always_comb begin
    hits    = 3'd0;
    col_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        hits    = hits + 3'd1;
        col_row = 2'(r);
      end
    end
    code_d      = (hits == 3'd1) ? {col_row, col_idx_q} : frame_code_q;
    sum         = {1'b0, frame_cnt_q} + hits;
    frame_cnt_d = (sum > 3'd2) ? 2'd2 : sum[1:0];
  end

  assign single = (frame_cnt_d == 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      col_idx_q    <= 2'd0;
      col_n_q      <= 4'b1110;
      row_s1_q     <= 4'hF;
      row_s2_q     <= 4'hF;
      frame_cnt_q  <= 2'd0;
      frame_code_q <= 4'd0;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
      if (tick) begin
        presc_q   <= '0;
        col_idx_q <= col_nx;
        col_n_q   <= ~(4'b0001 << col_nx);
        if (col_idx_q == 2'd3) begin
          frame_cnt_q  <= 2'd0;
          frame_code_q <= 4'd0;
        end else begin
          frame_cnt_q  <= frame_cnt_d;
          frame_code_q <= code_d;
        end
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= 16'd0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (frame_done) begin
        case (state_q)
          ST_IDLE: begin
            if (single) begin
              cand_q <= code_d;
              cnt_q  <= 4'd1;
              if (DEBOUNCE_SCANS == 1) begin
                state_q     <= ST_PRESSED;
                key_code_q  <= code_d;
                key_held_q  <= 1'b1;
                key_valid_q <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rpt_q       <= 16'(REPEAT_DELAY);
`endif
              end else begin
                state_q <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (single && code_d == cand_q) begin
              cnt_q <= cnt_nx;
              if (cnt_nx == 4'(DEBOUNCE_SCANS)) begin
                state_q     <= ST_PRESSED;
                key_code_q  <= cand_q;
                key_held_q  <= 1'b1;
                key_valid_q <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rpt_q       <= 16'(REPEAT_DELAY);
`endif
              end
            end else if (single) begin
              cand_q <= code_d;
              cnt_q  <= 4'd1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (single && code_d == cand_q) begin
`ifdef KEYPAD_REPEAT_EN
              if (rpt_q <= 16'd1) begin
                key_valid_q <= 1'b1;
                rpt_q       <= 16'(REPEAT_RATE);
              end else begin
                rpt_q <= rpt_q - 16'd1;
              end
`endif
            end else if (DEBOUNCE_SCANS == 1) begin
              state_q    <= ST_IDLE;
              key_held_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
              rpt_q      <= 16'd0;
`endif
            end else begin
              cnt_q   <= 4'd1;
              state_q <= ST_RELEASE;
            end
          end
          default: begin
            // A bounce back to the held key resumes PRESSED without a new strobe or repeat restart.
            if (single && code_d == cand_q) begin
              state_q <= ST_PRESSED;
            end else begin
              cnt_q <= cnt_nx;
              if (cnt_nx == 4'(DEBOUNCE_SCANS)) begin
                state_q    <= ST_IDLE;
                key_held_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
                rpt_q      <= 16'd0;
`endif
              end
            end
          end
        endcase
      end
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
